audio_capture: RTL and testbench
================================

AUDIO_CAPTURE -- requirements
Module: audio_capture

Interface
REQ-001 SHALL have parameter NSAMP, default 2000, meaning the number of stored samples per capture.
REQ-002 SHALL have parameter DECIM, default 4, meaning one sample is kept per DECIM accepted ADC samples.
REQ-003 SHALL have parameter THRESH, default 8'd20, meaning the trigger magnitude about mid-scale.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port adc_valid, input, 1 bit: adc_data is valid this cycle.
REQ-007 SHALL have port adc_data, input, 8 bits: unsigned offset-binary sample, 128 = silence.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request to begin a capture.
REQ-009 SHALL have port abort, input, 1 bit: single-cycle request to cancel and return to IDLE.
REQ-010 SHALL have port rd_addr, input, 11 bits: read address for the downstream comparator.
REQ-011 SHALL have port rd_data, output, 8 bits: signed two's-complement stored sample.
REQ-012 SHALL have port state, output, 3 bits: current FSM state code.
REQ-013 SHALL have port capture_done, output, 1 bit: a complete NSAMP buffer is held.

Function
REQ-014 SHALL implement states IDLE=3'b000, ARM=3'b001, CAPTURE=3'b011, DONE=3'b010; DONE equals the downstream compare-state code.
REQ-015 SHALL move IDLE->ARM on start, and also DONE->ARM on start, clearing capture_done the same cycle.
REQ-016 SHALL count accepted samples modulo DECIM in ARM and CAPTURE; only the sample where the count is 0 is "kept"; count resets to 0 on entering ARM.
REQ-017 SHALL convert every kept sample to signed by inverting bit 7 (adc_data ^ 8'h80).
REQ-018 SHALL, in ARM, trigger on the first kept sample with |signed value| >= THRESH; that sample is written to address 0 and the FSM enters CAPTURE.
REQ-019 SHALL, in CAPTURE, write each kept sample to the next address; the write pointer is 11 bits.
REQ-020 SHALL enter DONE on the cycle after the write to address NSAMP-1 and assert capture_done there; the pointer never wraps and no further writes occur.
REQ-021 SHALL ignore start in ARM and CAPTURE.
REQ-022 SHALL, on abort in any state, go to IDLE next cycle and clear capture_done and the pointer; abort wins over simultaneous start or a trigger.
REQ-023 SHALL register rd_data one cycle after rd_addr; rd_addr >= NSAMP returns 8'h00.
REQ-024 SHALL leave buffer contents undefined before the first completed capture; rd_data is only meaningful while capture_done = 1.

Reset
REQ-025 SHALL, while reset_n = 0, force state = IDLE, capture_done = 0, rd_data = 0, pointer = 0 and decimation count = 0, regardless of clk.
REQ-026 SHALL abandon a capture in progress on reset, with no partial-done indication afterwards.

Configuration
REQ-027 SHALL, with AUDIO_CAPTURE_TRIG_EN defined, use the threshold trigger of REQ-018.
REQ-028 SHALL, without AUDIO_CAPTURE_TRIG_EN, treat the first kept sample in ARM as the trigger regardless of magnitude; THRESH is unused.

Structure
REQ-029 SHALL take the state encoding typedef and the NSAMP default from the shared package audio_pkg, so downstream logic compares against the same DONE code.
REQ-030 SHALL place the sample storage in one sub-module, sample_ram: single write port and single registered read port, inferable as block RAM.

Verification
REQ-031 SHALL be verified by this scenario: reset, start, then a ramp of 100 samples at 128 followed by 200 ramp values starting at 180 -> the first value stored is 8'sd52; state sequence is 000->001->011.
REQ-032 SHALL be verified by this scenario: DECIM = 4, adc_valid every cycle, 8000 loud samples -> capture_done rises after the 2000th kept write; rd_addr 1999 returns the last kept value; rd_addr 2000 returns 0.
REQ-033 SHALL be verified by this scenario: 500 kept samples into CAPTURE, then abort pulsed together with start -> state = 000 next cycle and capture_done = 0.
REQ-034 SHALL be verified by this scenario: reset_n dropped mid-CAPTURE asynchronously -> outputs reach reset values before the next clk edge; a new start performs a full capture.
REQ-035 SHALL be verified by this scenario: with AUDIO_CAPTURE_TRIG_EN, silence of 128 only for 10000 cycles -> the FSM stays in ARM; without the macro, the same stimulus -> capture completes with all stored samples equal to 0.
REQ-036 SHALL be verified by this scenario: in DONE, start pulsed -> capture_done = 0 next cycle; state = 001.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture path: FSM state codes and default buffer depth.
// The DONE code is compared by downstream logic, so it lives here rather than in the capture block.
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_ARM     = 3'b001,
    ST_CAPTURE = 3'b011,
    ST_DONE    = 3'b010
  } cap_state_t;

  localparam int unsigned NSAMP_DEFAULT = 2000;
  localparam int unsigned ADDR_W        = 11;
  localparam int unsigned SAMPLE_W      = 8;

  // Offset-binary (128 = silence) to two's complement.
  function automatic logic [SAMPLE_W-1:0] to_signed_sample(input logic [SAMPLE_W-1:0] raw);
    return raw ^ 8'h80;
  endfunction

  // Magnitude of a two's-complement sample; -128 maps to 128.
  function automatic logic [SAMPLE_W-1:0] magnitude(input logic [SAMPLE_W-1:0] s);
    return s[SAMPLE_W-1] ? (~s + 8'd1) : s;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Sample buffer: one synchronous write port and one registered read port (block RAM style).
// Reads beyond DEPTH return zero; the read register clears on reset.
module sample_ram
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = NSAMP_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic                rd_in_range;

  assign rd_in_range = 32'(rd_addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/audio_capture.sv
// Triggered, decimating audio capture into an NSAMP-deep buffer with a registered read port.
// Define AUDIO_CAPTURE_TRIG_EN for the |sample| >= THRESH trigger; otherwise the first kept sample triggers.
module audio_capture
  import audio_pkg::*;
#(
  parameter int unsigned NSAMP  = NSAMP_DEFAULT,
  parameter int unsigned DECIM  = 4,
  parameter logic [7:0]  THRESH = 8'd20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adc_valid,
  input  logic [7:0]  adc_data,
  input  logic        start,
  input  logic        abort,
  input  logic [10:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic [2:0]  state,
  output logic        capture_done
);

  localparam int unsigned        CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(NSAMP - 1);

  cap_state_t          cur, nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                active, accept, kept, trig;
  logic [SAMPLE_W-1:0] sample;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;

  assign active = (cur == ST_ARM) || (cur == ST_CAPTURE);
  assign accept = adc_valid && active;
  assign kept   = accept && (cnt == '0);
  assign sample = to_signed_sample(adc_data);

`ifdef AUDIO_CAPTURE_TRIG_EN
  assign trig = magnitude(sample) >= THRESH;
`else
  logic [7:0] unused_thresh;
  assign unused_thresh = THRESH;
  assign trig          = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur <= ST_IDLE;
      ptr <= '0;
      cnt <= '0;
    end else begin
      cur <= nxt;
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    nxt     = cur;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_addr = ptr;

    if (accept) begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end

    // ARM and CAPTURE share the write/advance path; ARM only differs in forcing address 0.
    unique case (cur)
      ST_IDLE: begin
        if (start) begin
          nxt     = ST_ARM;
          ptr_nxt = '0;
          cnt_nxt = '0;
        end
      end
      ST_ARM, ST_CAPTURE: begin
        if (kept && (cur == ST_CAPTURE || trig)) begin
          wr_en   = 1'b1;
          wr_addr = (cur == ST_ARM) ? '0 : ptr;
          if (wr_addr == ADDR_LAST) begin
            nxt     = ST_DONE;
            ptr_nxt = wr_addr;
            cnt_nxt = '0;
          end else begin
            nxt     = ST_CAPTURE;
            ptr_nxt = wr_addr + 11'd1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          nxt     = ST_ARM;
          ptr_nxt = '0;
          cnt_nxt = '0;
        end
      end
      default: begin
        nxt     = ST_IDLE;
        ptr_nxt = '0;
        cnt_nxt = '0;
      end
    endcase

    if (abort) begin
      nxt     = ST_IDLE;
      ptr_nxt = '0;
      cnt_nxt = '0;
      wr_en   = 1'b0;
    end
  end

  assign state        = cur;
  assign capture_done = (cur == ST_DONE);

  sample_ram #(
    .DEPTH (NSAMP)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (sample),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_audio_capture.sv
// Directed bench for audio_capture: trigger, decimation, done/rearm, abort, async reset, silence.
// Expectations that depend on the trigger build option follow AUDIO_CAPTURE_TRIG_EN.
module tb_audio_capture;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adc_valid;
  logic [7:0]  adc_data;
  logic        start;
  logic        abort;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic [2:0]  state;
  logic        capture_done;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  audio_capture #(
    .NSAMP  (2000),
    .DECIM  (4),
    .THRESH (8'd20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .start        (start),
    .abort        (abort),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .state        (state),
    .capture_done (capture_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    step();
    adc_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic read(input logic [10:0] a, output logic [7:0] d);
    rd_addr = a;
    step();
    d = rd_data;
  endtask

  // Kept samples (every 4th) are loud: raw 200+k%50 -> stored 72+k%50; others are raw 0x00.
  function automatic logic [7:0] pat_a(input int unsigned i);
    if (i % 4 != 0) return 8'h00;
    return 8'(200 + (i / 4) % 50);
  endfunction

  // Kept samples raw 10+k%60 -> stored 138+k%60; others are raw 0xFF.
  function automatic logic [7:0] pat_b(input int unsigned i);
    if (i % 4 != 0) return 8'hFF;
    return 8'(10 + (i / 4) % 60);
  endfunction

  initial begin
    logic [7:0]  d;
    int unsigned n;
    int unsigned j;

    reset_n   = 1'b0;
    adc_valid = 1'b0;
    adc_data  = 8'd0;
    start     = 1'b0;
    abort     = 1'b0;
    rd_addr   = '0;

    #3;
    check("reset_state", 32'(state), 32'(3'b000));
    check("reset_done", 32'(capture_done), 0);
    check("reset_rd_data", 32'(rd_data), 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("idle_state", 32'(state), 32'(3'b000));

    // Silence then ramp from 180
    pulse_start();
    check("s1_arm", 32'(state), 32'(3'b001));
    for (int i = 0; i < 100; i++) feed(8'd128);
`ifdef AUDIO_CAPTURE_TRIG_EN
    check("s1_silence_state", 32'(state), 32'(3'b001));
`else
    check("s1_silence_state", 32'(state), 32'(3'b011));
`endif
    feed(8'd180);
    check("s1_trigger_state", 32'(state), 32'(3'b011));
    j = 1;
    n = 0;
    while (!capture_done && n < 10000) begin
      feed(8'(180 + j));
      j++;
      n++;
    end
    check("s1_done", 32'(capture_done), 1);
    check("s1_done_state", 32'(state), 32'(3'b010));
`ifdef AUDIO_CAPTURE_TRIG_EN
    read(11'd0, d);  check("s1_addr0", 32'(d), 52);
    read(11'd1, d);  check("s1_addr1", 32'(d), 56);
`else
    read(11'd0, d);  check("s1_addr0", 32'(d), 0);
    read(11'd24, d); check("s1_addr24", 32'(d), 0);
    read(11'd25, d); check("s1_addr25", 32'(d), 52);
`endif

    // Rearm from DONE, then full decimated capture of 8000 samples
    pulse_start();
    check("s2_done_clear", 32'(capture_done), 0);
    check("s2_rearm_state", 32'(state), 32'(3'b001));
    for (int i = 0; i < 7996; i++) feed(pat_a(i));
    check("s2_not_yet_done", 32'(capture_done), 0);
    check("s2_capture_state", 32'(state), 32'(3'b011));
    feed(pat_a(7996));
    check("s2_done", 32'(capture_done), 1);
    check("s2_done_state", 32'(state), 32'(3'b010));
    for (int i = 7997; i < 8000; i++) feed(pat_a(i));
    check("s2_still_done", 32'(state), 32'(3'b010));
    read(11'd0, d);    check("s2_addr0", 32'(d), 72);
    read(11'd1000, d); check("s2_addr1000", 32'(d), 72);
    read(11'd1037, d); check("s2_addr1037", 32'(d), 109);
    read(11'd1999, d); check("s2_addr1999", 32'(d), 121);
    read(11'd2000, d); check("s2_addr2000", 32'(d), 0);
    read(11'd2047, d); check("s2_addr2047", 32'(d), 0);

    // 500 kept samples, then abort together with start
    pulse_start();
    for (int i = 0; i < 1997; i++) feed(pat_a(i));
    check("s3_capture_state", 32'(state), 32'(3'b011));
    abort     = 1'b1;
    start     = 1'b1;
    adc_valid = 1'b1;
    adc_data  = 8'd200;
    step();
    abort     = 1'b0;
    start     = 1'b0;
    adc_valid = 1'b0;
    check("s3_abort_state", 32'(state), 32'(3'b000));
    check("s3_abort_done", 32'(capture_done), 0);
    step();
    check("s3_idle_hold", 32'(state), 32'(3'b000));

    // Asynchronous reset mid-capture, then a full capture
    pulse_start();
    check("s4_arm", 32'(state), 32'(3'b001));
    for (int i = 0; i < 400; i++) feed(pat_b(i));
    check("s4_capture_state", 32'(state), 32'(3'b011));
    rd_addr = 11'd0;
    step();
    #2 reset_n = 1'b0;
    #1;
    check("s4_async_state", 32'(state), 32'(3'b000));
    check("s4_async_done", 32'(capture_done), 0);
    check("s4_async_rd_data", 32'(rd_data), 0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) feed(pat_b(0));
    check("s4_post_reset_state", 32'(state), 32'(3'b000));
    check("s4_post_reset_done", 32'(capture_done), 0);
    pulse_start();
    n = 0;
    while (!capture_done && n < 9000) begin
      feed(pat_b(n));
      n++;
    end
    check("s4_len", n, 7997);
    check("s4_done", 32'(capture_done), 1);
    read(11'd0, d);    check("s4_addr0", 32'(d), 138);
    read(11'd5, d);    check("s4_addr5", 32'(d), 143);
    read(11'd1234, d); check("s4_addr1234", 32'(d), 172);
    read(11'd1999, d); check("s4_addr1999", 32'(d), 157);

    // Pure silence
    pulse_start();
    check("s5_arm", 32'(state), 32'(3'b001));
`ifdef AUDIO_CAPTURE_TRIG_EN
    for (int i = 0; i < 10000; i++) feed(8'd128);
    check("s5_stay_arm", 32'(state), 32'(3'b001));
    check("s5_no_done", 32'(capture_done), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s5_abort_state", 32'(state), 32'(3'b000));
`else
    n = 0;
    while (!capture_done && n < 10000) begin
      feed(8'd128);
      n++;
    end
    check("s5_len", n, 7997);
    check("s5_done", 32'(capture_done), 1);
    for (int a = 0; a < 2000; a++) begin
      read(11'(a), d);
      check("s5_zero", 32'(d), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
